// File: rtl/puf_helper_encoder.sv
// puf_helper_encoder: streams one 6-bit parity beat per 16-bit PUF word.
// Define HD_CHECKSUM_EN to append an XOR-of-parities checksum beat.
`ifndef IPID_WIDTH
`define IPID_WIDTH 32
`endif
`ifndef IPID_N
`define IPID_N 4
`endif

module puf_helper_encoder #(
    parameter int puf_sig_length = `IPID_WIDTH,
    parameter int ipid_N         = `IPID_N
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   enc_start,
    input  logic [puf_sig_length-1:0]              enc_puf_in,
    input  logic [$clog2(ipid_N)-1:0]              enc_ipid_number,
    output logic [5:0]                             hd_data,
    output logic [$clog2(puf_sig_length/16+1)-1:0] hd_word_idx,
    output logic [$clog2(ipid_N)-1:0]              hd_ipid,
    output logic                                   hd_valid,
    output logic                                   hd_last,
    input  logic                                   hd_ready,
    output logic                                   enc_busy,
    output logic                                   enc_done
);
    localparam int W  = puf_sig_length / 16;
    localparam int IW = $clog2(W + 1);
    localparam int PW = $clog2(ipid_N);
`ifdef HD_CHECKSUM_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [puf_sig_length-1:0] sig_q, sig_d;
    logic [PW-1:0]             ipid_q, ipid_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [5:0]                par_q, par_d;
    logic                      last_q, last_d;
    logic [IW-1:0]             idx_nxt;
    logic [5:0]                wpar;
`ifdef HD_CHECKSUM_EN
    logic [5:0]                csum_q, csum_d;
`endif

    function automatic logic [5:0] parity16(input logic [15:0] d);
        logic [5:0] p;
        p[0] = d[2] ^ d[5] ^ d[7] ^ d[9] ^ d[11] ^ d[14];
        p[1] = d[1] ^ d[4] ^ d[7] ^ d[8] ^ d[10] ^ d[13]
             ^ d[14] ^ d[15];
        p[2] = d[0] ^ d[4] ^ d[5] ^ d[6] ^ d[9] ^ d[10]
             ^ d[11] ^ d[12] ^ d[14] ^ d[15];
        p[3] = (^d[4:0]) ^ (^d[15:9]);
        p[4] = d[3] ^ d[6] ^ d[8] ^ d[9] ^ d[12] ^ d[13] ^ d[15];
        p[5] = (^d[9:0]) ^ d[14] ^ d[15];
        return p;
    endfunction

    function automatic logic [15:0] word_at(
        input logic [puf_sig_length-1:0] s,
        input logic [IW-1:0]             k
    );
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (IW'(i) == k) w = s[16*i +: 16];
        end
        return w;
    endfunction

    // Next-state logic: capture on start, advance one word per handshake.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        ipid_d  = ipid_q;
        idx_d   = idx_q;
        par_d   = par_q;
        last_d  = last_q;
`ifdef HD_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        idx_nxt = idx_q + IW'(1);
        wpar    = parity16(word_at(sig_q, idx_nxt));
        unique case (state_q)
            IDLE: begin
                if (enc_start) begin
                    state_d = SEND;
                    sig_d   = enc_puf_in;
                    ipid_d  = enc_ipid_number;
                    idx_d   = '0;
                    par_d   = parity16(enc_puf_in[15:0]);
                    last_d  = (LAST_IDX == '0);
`ifdef HD_CHECKSUM_EN
                    csum_d  = parity16(enc_puf_in[15:0]);
`endif
                end
            end
            SEND: begin
                if (hd_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_nxt;
                        last_d = (idx_nxt == LAST_IDX);
`ifdef HD_CHECKSUM_EN
                        if (idx_nxt == IW'(W)) begin
                            par_d = csum_q;
                        end else begin
                            par_d  = wpar;
                            csum_d = csum_q ^ wpar;
                        end
`else
                        par_d = wpar;
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= '0;
            ipid_q  <= '0;
            idx_q   <= '0;
            par_q   <= '0;
            last_q  <= 1'b0;
`ifdef HD_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            ipid_q  <= ipid_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            last_q  <= last_d;
`ifdef HD_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign hd_valid    = (state_q == SEND);
    assign hd_last     = last_q & hd_valid;
    assign hd_data     = par_q;
    assign hd_word_idx = idx_q;
    assign hd_ipid     = ipid_q;
    assign enc_busy    = (state_q != IDLE);
    assign enc_done    = (state_q == DONE);

endmodule

// File: tb/tb_puf_helper_encoder.sv
// tb_puf_helper_encoder: randomized and directed checks of the
// helper-data encoder against a mask-based parity reference model.
module tb_puf_helper_encoder;
    localparam int SL = 32;
    localparam int NI = 4;
    localparam int W  = SL / 16;
    localparam int IW = $clog2(W + 1);
    localparam int PW = $clog2(NI);
`ifdef HD_CHECKSUM_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam logic [15:0] MASK [6] = '{
        16'h4AA4, 16'hE592, 16'hDE71, 16'hFE1F, 16'hB348, 16'hC3FF
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enc_start = 1'b0;
    logic          hd_ready = 1'b0;
    logic [SL-1:0] enc_puf_in = '0;
    logic [PW-1:0] enc_ipid_number = '0;
    logic [5:0]    hd_data;
    logic [IW-1:0] hd_word_idx;
    logic [PW-1:0] hd_ipid;
    logic          hd_valid, hd_last, enc_busy, enc_done;

    int passed = 0;
    int total  = 0;

    logic [5:0]    got_data [$];
    logic [IW-1:0] got_idx  [$];
    logic          got_last [$];
    logic [PW-1:0] got_ipid [$];
    logic [5:0]    exp_data [$];
    logic [IW-1:0] exp_idx  [$];
    int done_cnt, done_cyc, unstable, busy_err, late_valid, stall_drop;
    bit timeout;

    always #5 clk = ~clk;

    puf_helper_encoder #(.puf_sig_length(SL), .ipid_N(NI)) dut (
        .clk(clk), .rst_n(rst_n), .enc_start(enc_start),
        .enc_puf_in(enc_puf_in), .enc_ipid_number(enc_ipid_number),
        .hd_data(hd_data), .hd_word_idx(hd_word_idx), .hd_ipid(hd_ipid),
        .hd_valid(hd_valid), .hd_last(hd_last), .hd_ready(hd_ready),
        .enc_busy(enc_busy), .enc_done(enc_done)
    );

    function automatic logic [5:0] ref_par(input logic [15:0] d);
        logic [5:0] p;
        for (int i = 0; i < 6; i++) p[i] = ^(d & MASK[i]);
        return p;
    endfunction

    task automatic build_expect(input logic [SL-1:0] s);
        logic [5:0] cs;
        exp_data.delete();
        exp_idx.delete();
        cs = '0;
        for (int k = 0; k < W; k++) begin
            exp_data.push_back(ref_par(s[16*k +: 16]));
            exp_idx.push_back(IW'(k));
            cs ^= ref_par(s[16*k +: 16]);
        end
`ifdef HD_CHECKSUM_EN
        exp_data.push_back(cs);
        exp_idx.push_back(IW'(W));
`endif
    endtask

    // Drives one record and captures every transferred beat.
    task automatic run(input logic [SL-1:0] s, input logic [PW-1:0] id,
                       input int pct, input int stall,
                       input bit busy_start, input bit done_start);
        logic [5:0]    h_data;
        logic [IW-1:0] h_idx;
        logic          h_last;
        bit            held;
        int            after;
        got_data.delete(); got_idx.delete();
        got_last.delete(); got_ipid.delete();
        done_cnt = 0; done_cyc = -1; unstable = 0; busy_err = 0;
        late_valid = 0; stall_drop = 0; timeout = 1; held = 0;
        after = 0; h_data = '0; h_idx = '0; h_last = 1'b0;
        enc_puf_in = s;
        enc_ipid_number = id;
        enc_start = 1'b1;
        hd_ready = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            enc_start = 1'b0;
            if (stall > 0) begin
                hd_ready = 1'b0;
                stall--;
                if (!hd_valid) stall_drop++;
            end else begin
                hd_ready = ($urandom_range(99) < pct);
            end
            if (busy_start && cyc == 2) begin
                enc_start = 1'b1;
                enc_puf_in = '1;
                enc_ipid_number = ~id;
            end
            if (done_cnt == 0 && !enc_busy) busy_err++;
            if (done_cnt > 0 && !enc_done && enc_busy) busy_err++;
            if (hd_valid) begin
                if (done_cnt > 0) late_valid++;
                if (held && (hd_data !== h_data || hd_word_idx !== h_idx
                             || hd_last !== h_last)) unstable++;
                if (hd_ready) begin
                    got_data.push_back(hd_data);
                    got_idx.push_back(hd_word_idx);
                    got_last.push_back(hd_last);
                    got_ipid.push_back(hd_ipid);
                    held = 0;
                end else begin
                    held = 1;
                    h_data = hd_data;
                    h_idx = hd_word_idx;
                    h_last = hd_last;
                end
            end
            if (enc_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (done_start) enc_start = 1'b1;
            end
            if (done_cnt > 0) begin
                after++;
                if (after > 4) begin
                    timeout = 0;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        enc_start = 1'b0;
        hd_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({hd_data, hd_word_idx, hd_ipid, hd_valid, hd_last,
             enc_busy, enc_done} !== '0)
            $display("FAIL reset_outputs: got %h %h %h %b %b %b %b want 0",
                     hd_data, hd_word_idx, hd_ipid, hd_valid, hd_last,
                     enc_busy, enc_done);
        else passed++;
        rst_n = 1'b1;
        hd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({hd_valid, enc_busy, enc_done} !== 3'b000)
            $display("FAIL idle_ready: got v%b b%b d%b want 000",
                     hd_valid, enc_busy, enc_done);
        else passed++;
        hd_ready = 1'b0;
    endtask

    task automatic test_known();
        run(32'h8000_0001, 2'd1, 100, 0, 0, 0);
        exp_data = '{6'h2C, 6'h3E};
        exp_idx = '{IW'(0), IW'(1)};
`ifdef HD_CHECKSUM_EN
        exp_data.push_back(6'h12);
        exp_idx.push_back(IW'(2));
`endif
        total++;
        if (got_data.size() != exp_data.size())
            $display("FAIL known_count: got %0d want %0d",
                     got_data.size(), exp_data.size());
        else passed++;
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            total++;
            if ({got_data[i], got_idx[i], got_last[i], got_ipid[i]} !==
                {exp_data[i], exp_idx[i], i == exp_data.size() - 1, 2'd1})
                $display("FAIL known_beat%0d: got %h/%0d/%b/%0d want %h/%0d/%b/1",
                         i, got_data[i], got_idx[i], got_last[i], got_ipid[i],
                         exp_data[i], exp_idx[i], i == exp_data.size() - 1);
            else passed++;
        end
        total++;
        if (timeout || done_cnt != 1 || done_cyc != NB + 1)
            $display("FAIL known_done: got cnt%0d cyc%0d to%0d want 1/%0d/0",
                     done_cnt, done_cyc, timeout, NB + 1);
        else passed++;
        total++;
        if (busy_err != 0 || late_valid != 0)
            $display("FAIL known_busy: got busy_err %0d late %0d want 0/0",
                     busy_err, late_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        build_expect(32'h8000_0001);
        run(32'h8000_0001, 2'd1, 100, 5, 0, 0);
        total++;
        if (unstable != 0 || stall_drop != 0)
            $display("FAIL bp_hold: got unstable %0d drop %0d want 0/0",
                     unstable, stall_drop);
        else passed++;
        total++;
        if (got_data != exp_data || got_idx != exp_idx)
            $display("FAIL bp_beats: got %0d beats d0 %h want %0d d0 %h",
                     got_data.size(), got_data.size() ? got_data[0] : 6'h0,
                     exp_data.size(), exp_data[0]);
        else passed++;
        total++;
        if (timeout || done_cnt != 1 || done_cyc != NB + 6)
            $display("FAIL bp_done: got cnt%0d cyc%0d want 1/%0d",
                     done_cnt, done_cyc, NB + 6);
        else passed++;
    endtask

    task automatic test_busy_start();
        build_expect(32'h8000_0001);
        run(32'h8000_0001, 2'd1, 100, 0, 1, 1);
        total++;
        if (got_data != exp_data || got_idx != exp_idx)
            $display("FAIL busy_beats: got %0d beats d0 %h want %0d d0 %h",
                     got_data.size(), got_data.size() ? got_data[0] : 6'h0,
                     exp_data.size(), exp_data[0]);
        else passed++;
        total++;
        if (got_ipid.size() == 0 || got_ipid[$] !== 2'd1)
            $display("FAIL busy_ipid: got %0d want 1",
                     got_ipid.size() ? got_ipid[$] : 2'd0);
        else passed++;
        total++;
        if (busy_err != 0 || late_valid != 0 || done_cnt != 1)
            $display("FAIL done_start: got busy_err %0d late %0d cnt %0d want 0/0/1",
                     busy_err, late_valid, done_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int bad;
        enc_puf_in = 32'h8000_0001;
        enc_ipid_number = 2'd1;
        enc_start = 1'b1;
        hd_ready = 1'b1;
        @(posedge clk); #1;
        enc_start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({hd_data, hd_word_idx, hd_ipid, hd_valid, hd_last,
             enc_busy, enc_done} !== '0)
            $display("FAIL midreset_outputs: got %h %h %h %b %b %b %b want 0",
                     hd_data, hd_word_idx, hd_ipid, hd_valid, hd_last,
                     enc_busy, enc_done);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (hd_valid || enc_done || enc_busy) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL midreset_quiet: got %0d active cycles want 0", bad);
        else passed++;
        hd_ready = 1'b0;
        build_expect('0);
        run('0, 2'd0, 100, 0, 0, 0);
        total++;
        if (got_data != exp_data || got_idx != exp_idx || done_cnt != 1)
            $display("FAIL midreset_fresh: got %0d beats cnt %0d want %0d/1",
                     got_data.size(), done_cnt, exp_data.size());
        else passed++;
    endtask

    task automatic test_zero();
        int nz;
        run('0, 2'd2, 100, 0, 0, 0);
        nz = 0;
        foreach (got_data[i]) if (got_data[i] !== 6'h00) nz++;
        total++;
        if (nz != 0 || got_data.size() != NB)
            $display("FAIL zero_beats: got %0d nonzero of %0d want 0 of %0d",
                     nz, got_data.size(), NB);
        else passed++;
        total++;
        if (timeout || done_cyc != NB + 1)
            $display("FAIL zero_done: got cyc %0d want %0d", done_cyc, NB + 1);
        else passed++;
    endtask

    task automatic test_random();
        logic [63:0]   r;
        logic [PW-1:0] id;
        int            nl;
        for (int it = 0; it < 20; it++) begin
            r = {$urandom(), $urandom()};
            id = PW'($urandom_range(NI - 1));
            build_expect(r[SL-1:0]);
            run(r[SL-1:0], id, 60, $urandom_range(3), 0, 0);
            nl = 0;
            foreach (got_last[i]) if (got_last[i] !== (i == NB - 1)) nl++;
            foreach (got_ipid[i]) if (got_ipid[i] !== id) nl++;
            total++;
            if (got_data != exp_data || got_idx != exp_idx || nl != 0)
                $display("FAIL rand%0d_beats: got %0d beats tagerr %0d sig %h want %0d",
                         it, got_data.size(), nl, r[SL-1:0], exp_data.size());
            else passed++;
            total++;
            if (timeout || done_cnt != 1 || unstable != 0 || busy_err != 0)
                $display("FAIL rand%0d_ctrl: got to%0d cnt%0d unst%0d busy%0d want 0/1/0/0",
                         it, timeout, done_cnt, unstable, busy_err);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_backpressure();
        test_busy_start();
        test_reset_mid();
        test_zero();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
